// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM compute sequencer.
package pwm_sched_pkg;

  localparam int FIFO_DEPTH_DEF     = 512;  // output FIFO capacity in 64-bit beats
  localparam int BEATS_PER_POLY_DEF = 128;  // 256 coeffs, 2 per beat
  localparam int CRED_W_DEF         = 10;   // must hold FIFO_DEPTH
  localparam int BEAT_W             = 11;   // holds 15 * 128 = 1920

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Number of output beats a full row produces.
  function automatic logic [BEAT_W-1:0] row_beats(input logic [3:0] cols,
                                                  input int beats_per_poly);
    return BEAT_W'(int'(cols) * beats_per_poly);
  endfunction

endpackage

// File: rtl/pwm_sched_if.sv
// Job command handshake between a host and the PWM sequencer.
interface pwm_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_rows;
  logic [3:0] cmd_cols;

  modport master (output cmd_valid, output cmd_rows, output cmd_cols, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rows, input cmd_cols, output cmd_ready);
endinterface

// File: rtl/pwm_sched_credit_ctr.sv
// Free-slot credit counter for the output FIFO. Starts full, one credit is
// consumed per datapath input read and returned per downstream pop. A pop
// with the counter already full saturates and flags an overflow pulse.
module pwm_sched_credit_ctr
  import pwm_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CRED_W     = CRED_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic empty,
  output logic ovf
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(FIFO_DEPTH);

  logic [CRED_W-1:0] credits_reg;
  logic              ovf_reg;

  // Credit update; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg <= FULL;
      ovf_reg     <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      case ({inc, dec})
        2'b10: begin
          if (credits_reg == FULL) ovf_reg <= 1'b1;
          else                     credits_reg <= credits_reg + CRED_W'(1);
        end
        2'b01: begin
          // The read gate keeps this from happening at zero; guard anyway.
          if (credits_reg != '0) credits_reg <= credits_reg - CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign empty = (credits_reg == '0);
  assign ovf   = ovf_reg;

endmodule

// File: rtl/pwm_sched.sv
// Sequencer for the pointwise-multiply datapath: runs a rows x cols job one
// row at a time, gates datapath reads with output-FIFO credits (the datapath
// ignores backpressure) and waits for every output beat before the next row.
module pwm_sched
  import pwm_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int BEATS_PER_POLY = BEATS_PER_POLY_DEF,
  parameter int CRED_W         = CRED_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pwm_sched_if.slave  cmd,
  input  logic        abort,
  output logic        compute_start,
  output logic        compu_working,
  output logic [3:0]  column_length,
  input  logic        compute_done,
  input  logic        ram_read,
  input  logic        out_beat,
  input  logic        fifo_pop,
  output logic [3:0]  row_idx,
  output logic        busy,
  output logic        job_done,
  output logic        err
);

  state_t              state_reg;
  logic [3:0]          rows_reg;
  logic [3:0]          cols_reg;
  logic [3:0]          row_idx_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic                start_reg;
  logic                done_reg;
  logic                cmd_err_reg;

  logic                cred_empty;
  logic                cred_ovf;
  logic [BEAT_W-1:0]   beats_target;
  logic                last_row;
  logic                in_job;

  pwm_sched_credit_ctr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CRED_W     (CRED_W)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .dec   (ram_read),
    .inc   (fifo_pop),
    .empty (cred_empty),
    .ovf   (cred_ovf)
  );

  assign beats_target = row_beats(cols_reg, BEATS_PER_POLY);
  assign last_row     = (row_idx_reg == rows_reg - 4'd1);
  assign in_job       = (state_reg != ST_IDLE);

  // Job FSM with row/beat counters and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rows_reg     <= '0;
      cols_reg     <= '0;
      row_idx_reg  <= '0;
      beat_cnt_reg <= '0;
      start_reg    <= 1'b0;
      done_reg     <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      start_reg   <= 1'b0;
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;

      // Output beats count only while a row is in flight; saturate, never wrap.
      if ((state_reg == ST_RUN || state_reg == ST_DRAIN) && out_beat && beat_cnt_reg != '1)
        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);

      if (abort && in_job) begin
        // Credits are left alone: in-flight beats still land in the FIFO.
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmd.cmd_valid) begin
              if (cmd.cmd_rows == 4'd0 || cmd.cmd_cols == 4'd0) begin
                cmd_err_reg <= 1'b1;
              end else begin
                rows_reg    <= cmd.cmd_rows;
                cols_reg    <= cmd.cmd_cols;
                row_idx_reg <= '0;
                start_reg   <= 1'b1;
                state_reg   <= ST_START;
              end
            end
          end
          ST_START: begin
            beat_cnt_reg <= '0;
            state_reg    <= ST_RUN;
          end
          ST_RUN: begin
            if (compute_done) state_reg <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (beat_cnt_reg == beats_target) begin
              if (last_row) begin
                done_reg  <= 1'b1;
                state_reg <= ST_FIN;
              end else begin
                row_idx_reg <= row_idx_reg + 4'd1;
                start_reg   <= 1'b1;
                state_reg   <= ST_START;
              end
            end
          end
          ST_FIN: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Abort suppresses pulses and the read gate in the cycle it is seen.
  assign compute_start = start_reg & ~abort;
  assign job_done      = done_reg & ~abort;
  assign compu_working = (state_reg == ST_RUN) & ~cred_empty & ~abort;
  assign column_length = cols_reg;
  assign row_idx       = row_idx_reg;
  assign busy          = in_job;
  assign err           = cmd_err_reg | cred_ovf;
  assign cmd.cmd_ready = ~in_job;

endmodule

// File: tb/tb_pwm_sched.sv
// Directed testbench for pwm_sched: full job, zero-size command, credit
// exhaustion and refill, overflow, abort and asynchronous reset.
module tb_pwm_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort, compute_done, ram_read, out_beat, fifo_pop;
  logic       compute_start, compu_working, busy, job_done, err;
  logic [3:0] column_length, row_idx;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int sb, db, reads;

  always #5 clk = ~clk;

  pwm_sched_if cmd_if ();

  pwm_sched #(
    .FIFO_DEPTH     (512),
    .BEATS_PER_POLY (128),
    .CRED_W         (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (cmd_if),
    .abort         (abort),
    .compute_start (compute_start),
    .compu_working (compu_working),
    .column_length (column_length),
    .compute_done  (compute_done),
    .ram_read      (ram_read),
    .out_beat      (out_beat),
    .fifo_pop      (fifo_pop),
    .row_idx       (row_idx),
    .busy          (busy),
    .job_done      (job_done),
    .err           (err)
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (compute_start === 1'b1) start_cnt++;
    if (job_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic dp_idle();
    ram_read = 1'b0; out_beat = 1'b0; fifo_pop = 1'b0; compute_done = 1'b0; abort = 1'b0;
  endtask

  // One complete row, entered with START visible. Reads at 1..n, beats lag
  // by 3, pops lag by 4, compute_done right after the last read.
  task automatic run_row(input int cols, input int row, input bit last);
    int n;
    n = cols * 128;
    chk("row_start_pulse", compute_start, 1);
    chk("row_idx", row_idx, row);
    chk("column_length", column_length, cols);
    for (int i = 0; i <= n + 4; i++) begin
      ram_read     = (i >= 1 && i <= n);
      out_beat     = (i >= 4 && i <= n + 3);
      fifo_pop     = (i >= 5 && i <= n + 4);
      compute_done = (i == n + 1);
      tick();
      if (i == 0) begin
        chk("run_start_low", compute_start, 0);
        chk("run_working", compu_working, 1);
      end
      if (i == n + 3) begin
        chk("drain_busy", busy, 1);
        chk("drain_no_working", compu_working, 0);
        chk("drain_hold_start", compute_start, 0);
        chk("drain_hold_done", job_done, 0);
      end
    end
    dp_idle();
    if (last) chk("drain_exit_done", job_done, 1);
    else      chk("drain_exit_start", compute_start, 1);
  endtask

  initial begin
    rst = 1'b1;
    dp_idle();
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_rows = 4'd0; cmd_if.cmd_cols = 4'd0;
    tick();
    // Reset state
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", compute_start, 0);
    chk("rst_working", compu_working, 0);
    chk("rst_col_len", column_length, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_done", job_done, 0);
    chk("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: rows=2 cols=3, extra commands during the job are ignored
    $display("[TB] step1 job rows=2 cols=3");
    sb = start_cnt; db = done_cnt;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd2; cmd_if.cmd_cols = 4'd3;
    tick();
    cmd_if.cmd_rows = 4'd7; cmd_if.cmd_cols = 4'd9;
    chk("job_cmd_ready_low", cmd_if.cmd_ready, 0);
    chk("job_busy", busy, 1);
    run_row(3, 0, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    run_row(3, 1, 1'b1);
    tick();
    chk("fin_done_low", job_done, 0);
    chk("fin_cmd_ready", cmd_if.cmd_ready, 1);
    chk("fin_busy", busy, 0);
    chk("job1_starts", start_cnt - sb, 2);
    chk("job1_dones", done_cnt - db, 1);
    chk("job1_err", err, 0);

    // 2: zero-size commands
    $display("[TB] step2 zero-size commands");
    sb = start_cnt;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd0; cmd_if.cmd_cols = 4'd5;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("zrows_err", err, 1);
    chk("zrows_busy", busy, 0);
    chk("zrows_ready", cmd_if.cmd_ready, 1);
    tick();
    chk("zrows_err_pulse", err, 0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd4; cmd_if.cmd_cols = 4'd0;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("zcols_err", err, 1);
    chk("zcols_busy", busy, 0);
    tick();
    chk("zero_no_start", start_cnt - sb, 0);

    // 4: balanced traffic and overflow at full credits
    $display("[TB] step4 balanced credits and overflow");
    for (int k = 0; k < 4; k++) begin
      ram_read = 1'b1; fifo_pop = 1'b1;
      tick();
      chk("balanced_no_err", err, 0);
    end
    ram_read = 1'b0; fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("ovf_pulse", err, 1);
    tick();
    chk("ovf_pulse_end", err, 0);
    ram_read = 1'b1;
    tick();
    ram_read = 1'b0; fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("refill_no_err", err, 0);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("ovf_still_512", err, 1);
    tick();

    // 3: credit exhaustion with no pops
    $display("[TB] step3 credit exhaustion rows=1 cols=5");
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd1; cmd_if.cmd_cols = 4'd5;
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("ex_start", compute_start, 1);
    chk("ex_start_no_working", compu_working, 0);
    tick();
    reads = 0;
    for (int k = 0; k < 600 && reads < 512; k++) begin
      ram_read = compu_working;
      if (compu_working === 1'b1) reads++;
      tick();
      if (reads == 511) chk("ex_working_511", compu_working, 1);
    end
    ram_read = 1'b0;
    chk("ex_reads", reads, 512);
    chk("ex_working_zero", compu_working, 0);
    tick();
    chk("ex_working_stays_zero", compu_working, 0);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("ex_working_reraise", compu_working, 1);
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("ex_drain_no_working", compu_working, 0);
    for (int j = 0; j < 640; j++) begin
      out_beat = 1'b1;
      fifo_pop = (j < 511);
      tick();
    end
    dp_idle();
    chk("ex_drain_no_done", job_done, 0);
    chk("ex_drain_busy", busy, 1);
    tick();
    chk("ex_done", job_done, 1);
    tick();
    chk("ex_idle", cmd_if.cmd_ready, 1);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("ex_credits_full", err, 1);
    tick();

    // 5: abort during row 1 of 3
    $display("[TB] step5 abort rows=3 cols=1");
    sb = start_cnt; db = done_cnt;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd3; cmd_if.cmd_cols = 4'd1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    run_row(1, 0, 1'b0);
    chk("ab_row1", row_idx, 1);
    for (int i = 0; i <= 10; i++) begin
      ram_read = (i >= 1);
      out_beat = (i >= 4);
      tick();
    end
    ram_read = 1'b0; out_beat = 1'b0;
    chk("ab_working_before", compu_working, 1);
    abort = 1'b1;
    #1;
    chk("ab_working_drop", compu_working, 0);
    tick();
    abort = 1'b0;
    chk("ab_cmd_ready", cmd_if.cmd_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_no_start", compute_start, 0);
    tick();
    chk("ab_starts", start_cnt - sb, 2);
    chk("ab_no_done", done_cnt - db, 0);
    for (int k = 0; k < 10; k++) begin
      fifo_pop = 1'b1;
      tick();
      chk("ab_popback_no_err", err, 0);
    end
    tick();
    fifo_pop = 1'b0;
    chk("ab_credits_512", err, 1);
    tick();

    // 6: asynchronous reset in DRAIN
    $display("[TB] step6 async reset in drain");
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_rows = 4'd1; cmd_if.cmd_cols = 4'd1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i <= 130; i++) begin
      ram_read     = (i >= 1 && i <= 128);
      out_beat     = (i >= 4 && i <= 50);
      compute_done = (i == 129);
      tick();
    end
    dp_idle();
    chk("ar_pre_busy", busy, 1);
    chk("ar_pre_col_len", column_length, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_cmd_ready", cmd_if.cmd_ready, 1);
    chk("ar_start", compute_start, 0);
    chk("ar_working", compu_working, 0);
    chk("ar_col_len", column_length, 0);
    chk("ar_row_idx", row_idx, 0);
    chk("ar_err", err, 0);
    chk("ar_done", job_done, 0);
    tick();
    rst = 1'b0;
    tick();
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    chk("ar_credits_512", err, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
